// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select, load-use stall and store-to-load forwarding.
// Ports: src/stg operand inputs, st_/ld_ store buffer, fwd_sel, stall, ld_fwd_*.
// Optional HAZARD_STATS_EN adds stat_clr and stat_*_cnt counters.
module hazard_fwd_unit #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int STQ_DEPTH  = 4,
  parameter int SEL_W      = $clog2(FWD_STAGES+1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*RA_W-1:0]     src_addr,
  input  logic [FWD_STAGES-1:0]       stg_wr_en,
  input  logic [FWD_STAGES*RA_W-1:0]  stg_wr_addr,
  input  logic [FWD_STAGES-1:0]       stg_is_load,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [XLEN-1:0]             st_addr,
  input  logic [XLEN-1:0]             st_data,
  input  logic                        st_drain,
  input  logic                        ld_valid,
  input  logic [XLEN-1:0]             ld_addr,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        load_use_stall,
  output logic                        ld_fwd_hit,
  output logic [XLEN-1:0]             ld_fwd_data,
  output logic [$clog2(STQ_DEPTH+1)-1:0] stq_count
`ifdef HAZARD_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [31:0]                 stat_stall_cnt,
  output logic [31:0]                 stat_fwd_cnt,
  output logic [31:0]                 stat_stld_cnt
`endif
);

  localparam int CNT_W = $clog2(STQ_DEPTH+1);
  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int WA_W  = XLEN-2;

  logic [NUM_SRC*SEL_W-1:0] sel_d;
  logic [NUM_SRC-1:0]       win_ld;
  logic                     stall_d;

  // Descending scan: the youngest (lowest index) match is written last.
  always_comb begin
    sel_d  = '0;
    win_ld = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = FWD_STAGES-1; s >= 0; s--) begin
        if (src_valid[i] &&
            src_addr[i*RA_W +: RA_W] != '0 &&
            stg_wr_en[s] &&
            stg_wr_addr[s*RA_W +: RA_W] ==
              src_addr[i*RA_W +: RA_W]) begin
          sel_d[i*SEL_W +: SEL_W] = SEL_W'(s+1);
          win_ld[i] = stg_is_load[s];
        end
      end
    end
    stall_d = |win_ld;
  end

  assign load_use_stall = stall_d;

  logic [WA_W-1:0]      sb_addr [STQ_DEPTH];
  logic [XLEN-1:0]      sb_data [STQ_DEPTH];
  logic [STQ_DEPTH-1:0] sb_vld;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     cnt;
  logic                 push;
  logic                 pop;

  assign st_ready  = (cnt < CNT_W'(STQ_DEPTH)) | st_drain;
  assign push      = st_valid & st_ready;
  assign pop       = st_drain & (cnt != '0);
  assign stq_count = cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_vld <= '0;
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
    end else begin
      // Pop first so a full-buffer push into the freed slot stays valid.
      if (pop) begin
        sb_vld[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        sb_vld[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= st_addr[XLEN-1:2];
      sb_data[tail] <= st_data;
    end
  end

  logic            lk_hit;
  logic [XLEN-1:0] lk_data;
  logic [PTR_W-1:0] idx;

  // Oldest to youngest from head; later matches override earlier ones.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int k = 0; k < STQ_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (sb_vld[idx] &&
          sb_addr[idx] == ld_addr[XLEN-1:2]) begin
        lk_hit  = 1'b1;
        lk_data = sb_data[idx];
      end
    end
    if (push && st_addr[XLEN-1:2] == ld_addr[XLEN-1:2]) begin
      lk_hit  = 1'b1;
      lk_data = st_data;
    end
  end

  logic [NUM_SRC*SEL_W-1:0] sel_q;
  logic                     ld_take;

  assign ld_take = ld_valid & ~flush & lk_hit;
  assign fwd_sel = sel_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q       <= '0;
      ld_fwd_hit  <= 1'b0;
      ld_fwd_data <= '0;
    end else begin
      sel_q      <= flush ? '0 : sel_d;
      ld_fwd_hit <= ld_take;
      if (ld_take) begin
        ld_fwd_data <= lk_data;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
      stat_stld_cnt  <= '0;
    end else if (stat_clr) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
      stat_stld_cnt  <= '0;
    end else begin
      if (stall_d && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 1'b1;
      if ((|sel_d) && stat_fwd_cnt != '1)
        stat_fwd_cnt <= stat_fwd_cnt + 1'b1;
      if (ld_fwd_hit && stat_stld_cnt != '1)
        stat_stld_cnt <= stat_stld_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [1:0]  src_valid;
  logic [9:0]  src_addr;
  logic [1:0]  stg_wr_en;
  logic [9:0]  stg_wr_addr;
  logic [1:0]  stg_is_load;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_drain;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_sel;
  logic        load_use_stall;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic [2:0]  stq_count;

  hazard_fwd_unit dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .src_valid(src_valid), .src_addr(src_addr),
    .stg_wr_en(stg_wr_en), .stg_wr_addr(stg_wr_addr),
    .stg_is_load(stg_is_load),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .st_drain(st_drain), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .fwd_sel(fwd_sel),
    .load_use_stall(load_use_stall),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .stq_count(stq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
  } st_ent_t;

  st_ent_t     sq[$];
  logic [31:0] exp_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; src_valid = 0; src_addr = 0;
    stg_wr_en = 0; stg_wr_addr = 0; stg_is_load = 0;
    st_valid = 0; st_addr = 0; st_data = 0;
    st_drain = 0; ld_valid = 0; ld_addr = 0;
  endtask

  // One clock: check combinational outputs, then registered ones.
  task automatic cyc();
    int      code [2];
    logic    e_stall, e_rdy, e_push, e_pop;
    logic    found, e_hit;
    logic [31:0] fd;
    logic [3:0]  e_sel;
    st_ent_t ne;
    #1;
    e_stall = 0;
    for (int i = 0; i < 2; i++) begin
      int ra;
      logic done;
      ra = int'(src_addr[i*5 +: 5]);
      code[i] = 0;
      done = 0;
      for (int s = 0; s < 2; s++) begin
        if (!done && src_valid[i] && ra != 0 &&
            stg_wr_en[s] &&
            int'(stg_wr_addr[s*5 +: 5]) == ra) begin
          code[i] = s + 1;
          done = 1;
          if (stg_is_load[s]) e_stall = 1;
        end
      end
    end
    chk("stall", load_use_stall, e_stall);
    e_rdy = (sq.size() < 4) || st_drain;
    chk("st_ready", st_ready, e_rdy);
    e_push = st_valid && e_rdy;
    e_pop  = st_drain && sq.size() > 0;
    found = 0;
    fd = 0;
    if (e_push && st_addr[31:2] == ld_addr[31:2]) begin
      found = 1;
      fd = st_data;
    end else begin
      for (int k = sq.size()-1; k >= 0; k--) begin
        if (!found && sq[k].wa == ld_addr[31:2]) begin
          found = 1;
          fd = sq[k].d;
        end
      end
    end
    e_hit = ld_valid && !flush && found;
    if (e_hit) exp_data = fd;
    e_sel = flush ? 4'd0 : 4'(code[1]*4 + code[0]);
    ne.wa = st_addr[31:2];
    ne.d  = st_data;
    @(posedge clk);
    #1;
    chk("fwd_sel", fwd_sel, e_sel);
    chk("ld_hit", ld_fwd_hit, e_hit);
    if (e_hit) chk("ld_data", ld_fwd_data, exp_data);
    if (e_pop) void'(sq.pop_front());
    if (e_push) sq.push_back(ne);
    chk("count", stq_count, sq.size());
  endtask

  initial begin
    idle();
    rstn = 0;
    exp_data = 0;
    #12;
    chk("rst_sel", fwd_sel, 0);
    chk("rst_hit", ld_fwd_hit, 0);
    chk("rst_data", ld_fwd_data, 0);
    chk("rst_cnt", stq_count, 0);
    chk("rst_rdy", st_ready, 1);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;

    // youngest producer wins, then older stage
    src_valid = 2'b11; src_addr = {5'd5, 5'd5};
    stg_wr_en = 2'b11; stg_wr_addr = {5'd5, 5'd5};
    cyc();
    chk("dir_sel11", fwd_sel, 4'b0101);
    stg_wr_en = 2'b10;
    cyc();
    chk("dir_sel22", fwd_sel, 4'b1010);

    // x0 never forwards
    src_addr = 0; stg_wr_en = 2'b01; stg_wr_addr = 0;
    cyc();
    chk("dir_x0", fwd_sel, 0);

    // load-use, then flush
    src_addr = {5'd7, 5'd3}; stg_wr_addr = {5'd0, 5'd7};
    stg_is_load = 2'b01;
    #1;
    chk("dir_stall", load_use_stall, 1);
    cyc();
    chk("dir_sel_ld", fwd_sel, 4'b0100);
    flush = 1;
    #1;
    chk("dir_stall_fl", load_use_stall, 1);
    cyc();
    chk("dir_flush", fwd_sel, 0);
    idle();

    // random operand traffic
    for (int n = 0; n < 60; n++) begin
      src_valid   = 2'($urandom);
      src_addr    = {5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3))};
      stg_wr_en   = 2'($urandom);
      stg_wr_addr = {5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3))};
      stg_is_load = 2'($urandom);
      flush       = ($urandom_range(0, 7) == 0);
      cyc();
    end
    idle();

    // store-to-load forwarding
    st_valid = 1; st_addr = 32'h100; st_data = 32'hAAAA;
    cyc();
    st_data = 32'hBBBB;
    cyc();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h102;
    cyc();
    chk("dir_ld_hit", ld_fwd_hit, 1);
    chk("dir_ld_data", ld_fwd_data, 32'hBBBB);
    ld_addr = 32'h104;
    cyc();
    chk("dir_ld_miss", ld_fwd_hit, 0);
    ld_valid = 0; st_drain = 1;
    cyc();
    cyc();
    chk("dir_drained", stq_count, 0);

    // full buffer behaviour
    st_drain = 0; st_valid = 1;
    for (int k = 0; k < 4; k++) begin
      st_addr = 32'h300 + 32'(k*4);
      st_data = 32'h5000 + 32'(k);
      cyc();
    end
    st_valid = 0;
    #1;
    chk("dir_full_cnt", stq_count, 4);
    chk("dir_full_rdy", st_ready, 0);
    st_valid = 1; st_drain = 1; st_addr = 32'h320;
    cyc();
    chk("dir_pushpop", stq_count, 4);
    st_valid = 0;
    for (int k = 0; k < 5; k++) cyc();
    chk("dir_empty", stq_count, 0);
    st_drain = 0;

    // same-cycle bypass
    st_valid = 1; st_addr = 32'h200; st_data = 32'h1234;
    ld_valid = 1; ld_addr = 32'h200;
    cyc();
    chk("dir_byp_hit", ld_fwd_hit, 1);
    chk("dir_byp_data", ld_fwd_data, 32'h1234);
    idle();

    // random store buffer traffic
    for (int n = 0; n < 100; n++) begin
      st_valid = ($urandom_range(0, 1) == 1);
      st_addr  = 32'h100 + 32'($urandom_range(0, 11));
      st_data  = $urandom;
      st_drain = ($urandom_range(0, 2) == 0);
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_addr  = 32'h100 + 32'($urandom_range(0, 11));
      flush    = ($urandom_range(0, 9) == 0);
      cyc();
    end

    // asynchronous reset mid-operation
    idle();
    st_valid = 1; st_addr = 32'h40; st_data = 32'h77;
    cyc();
    idle();
    #2;
    rstn = 0;
    #1;
    sq.delete();
    exp_data = 0;
    chk("mrst_sel", fwd_sel, 0);
    chk("mrst_hit", ld_fwd_hit, 0);
    chk("mrst_data", ld_fwd_data, 0);
    chk("mrst_cnt", stq_count, 0);
    chk("mrst_rdy", st_ready, 1);
    chk("mrst_stall", load_use_stall, 0);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    ld_valid = 1; ld_addr = 32'h40;
    cyc();
    chk("mrst_nohit", ld_fwd_hit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised operand-forwarding and hazard unit for the 4-stage core. It is the successor to the fixed 2-source, 2-producer, single-entry store/load checker. It resolves RAW hazards for NUM_SRC source operands against FWD_STAGES in-flight producer stages, and raises a load-use stall. It also holds a circular store buffer of recent stores for store-to-load forwarding.

Parameters:
XLEN, 32, datapath and address width
RA_W, 5, register address width
NUM_SRC, 2, number of source operands checked per cycle
FWD_STAGES, 2, number of producer stages; index 0 = youngest (EXE), FWD_STAGES-1 = oldest (WB)
STQ_DEPTH, 4, store buffer entries; power of 2, minimum 2
SEL_W, $clog2(FWD_STAGES+1), forward-select code width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; clears registered hazard outputs
src_valid  in  NUM_SRC  source operand i is used
src_addr  in  NUM_SRC*RA_W  source register addresses, operand i at [i*RA_W +: RA_W]
stg_wr_en  in  FWD_STAGES  producer stage s writes the register file
stg_wr_addr  in  FWD_STAGES*RA_W  producer destination addresses
stg_is_load  in  FWD_STAGES  producer s is a load whose data is not yet available
st_valid  in  1  store push request
st_ready  out  1  store buffer can accept a push
st_addr  in  XLEN  store byte address
st_data  in  XLEN  store word data
st_drain  in  1  oldest buffered store has been written to memory; pop it
ld_valid  in  1  load lookup request
ld_addr  in  XLEN  load byte address
fwd_sel  out  NUM_SRC*SEL_W  registered select per operand: 0 = regfile, s+1 = stage s
load_use_stall  out  1  combinational stall request
ld_fwd_hit  out  1  registered store-to-load hit
ld_fwd_data  out  XLEN  registered forwarded store data
stq_count  out  $clog2(STQ_DEPTH+1)  buffer occupancy

Behaviour:
- Reset (rstn low, asynchronous): fwd_sel=0, ld_fwd_hit=0, ld_fwd_data=0, buffer empty (all entries invalid, head=tail=0, stq_count=0), st_ready=1.
- Operand match: stage s matches operand i when src_valid[i], src_addr_i!=0, stg_wr_en[s], and stg_wr_addr_s==src_addr_i.
- Priority: the lowest matching s wins (youngest producer). No match gives code 0.
- fwd_sel is registered with 1-cycle latency: code computed in cycle N appears in N+1. flush takes priority and forces the register to 0.
- load_use_stall is combinational: asserted if, for any operand, the winning stage has stg_is_load=1. It is not gated by flush.
- Store buffer: circular FIFO. Push on st_valid & st_ready and write {addr[XLEN-1:2], data} at tail. Pop on st_drain & (count>0).
- st_ready = (count<STQ_DEPTH) | st_drain. A simultaneous push and pop when full is legal and leaves count unchanged.
- Pointers wrap modulo STQ_DEPTH. st_drain with count=0 is ignored. st_valid while st_ready=0 is dropped; the store stage must hold until ready.
- Load lookup compares word address ld_addr[XLEN-1:2] against all valid entries plus the store being pushed in the same cycle (bypass).
- The youngest match wins, with the same-cycle push youngest of all. Result is registered: ld_fwd_hit/ld_fwd_data valid the cycle after ld_valid.
- ld_valid=0 gives ld_fwd_hit=0 next cycle; ld_fwd_data holds its last value.
- An entry popped in the same cycle as a lookup still participates in that lookup.
- flush does not modify the store buffer (buffered stores are committed). flush clears ld_fwd_hit next cycle.
- stq_count updates the cycle after push/pop.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stat_stall_cnt[31:0], stat_fwd_cnt[31:0], stat_stld_cnt[31:0] and input stat_clr.
  - Counters increment per cycle with load_use_stall, with any nonzero fwd_sel code computed, and with ld_fwd_hit set, respectively.
  - They saturate at all-ones; stat_clr or reset zeroes them.
- Undefined: no counter ports, no counter logic.

Test Plan:
- NUM_SRC=2, FWD_STAGES=2: src_addr={x5,x5}, stage0 writes x5, stage1 writes x5 -> fwd_sel={1,1} next cycle; drop stg_wr_en[0] -> {2,2}.
- src_addr x0, stage0 writes x0 with wr_en=1 -> fwd_sel=0; load_use_stall=0.
- Stage0 load (stg_is_load=1) to x7, src1=x7 -> load_use_stall=1 same cycle. Assert flush -> fwd_sel=0 next cycle, stall still 1.
- Push stores 0x100/0xAAAA then 0x100/0xBBBB, load 0x102 -> ld_fwd_hit=1, data 0xBBBB next cycle. Load 0x104 -> hit=0.
- STQ_DEPTH=4: push 4 stores -> stq_count=4, st_ready=0. Push with st_drain -> accepted, count stays 4. Drain 5 times -> count 0, extra drain ignored.
- Same-cycle store push 0x200/0x1234 and load 0x200 -> hit=1, data 0x1234 next cycle. Reset mid-operation -> all outputs 0, count 0.
